cmd_frame_decoder: RTL and testbench
====================================

Name: cmd_frame_decoder

Overview:
- Parametrised UART command-frame decoder and configuration register bank. Successor to the fixed 5-byte, 13-register inline parser in the top level.
- Consumes bytes from UART_RX via the busy falling edge. Assembles frames of one command byte plus DATA_BYTES payload bytes, then writes one register of a NUM_REGS-deep bank.
- Adds an inter-byte timeout with resync, an invalid-command error flag and a per-write strobe. Drives MAWG control inputs from the flattened bank.

Parameters:
NUM_REGS, 16, number of registers; valid addresses 0..NUM_REGS-1 (NUM_REGS <= 255)
DATA_BYTES, 4, payload bytes per frame; register width = 8*DATA_BYTES (1..4)
TIMEOUT_CYCLES, 1000, max clk cycles between bytes inside a frame before abort (>= 2)
CLEAR_CMD, 8'hFF, command byte that zeroes the whole bank (must be >= NUM_REGS)

Ports:
clk  input  1  system clock (CLK_1M domain in the top level)
rst  input  1  reset, asynchronous, active-low
rx_data  input  8  UART received byte; valid when rx_busy falls
rx_busy  input  1  UART busy; a 1->0 transition marks one received byte
regs_flat  output  NUM_REGS*DATA_BYTES*8  register bank; reg k occupies bits [(k+1)*W-1 : k*W], W=8*DATA_BYTES
wr_strobe  output  1  one-cycle pulse when a register is written or cleared
wr_addr  output  8  address of the last write (CLEAR_CMD for a clear)
frame_err  output  1  one-cycle pulse on timeout, invalid command or checksum mismatch
busy  output  1  high while a frame is partially received (state != IDLE)

Behaviour:
- Reset (rst low, async): state=IDLE; regs_flat, wr_addr, byte counter, timeout counter, shift buffer all 0; wr_strobe=0, frame_err=0, prev_busy=0.
- byte_evt = prev_busy & ~rx_busy. prev_busy is registered every cycle. A busy held low out of reset never produces an event.
- States: IDLE, DATA, CHK (only with CHECKSUM_EN).
- IDLE: on byte_evt, latch cmd=rx_data, clear count, go DATA. No other action in IDLE.
- DATA: on byte_evt, buff <= {buff[W-9:0], rx_data}, so payload is big-endian (first byte = MSB).
  - On the DATA_BYTES-th byte, go to CHK if enabled; otherwise commit on that same edge and return to IDLE.
- Commit, on the clock edge of the final byte_evt:
  - cmd < NUM_REGS: reg[cmd] <= assembled word; wr_strobe=1; wr_addr=cmd.
  - cmd == CLEAR_CMD: all registers 0; wr_strobe=1; wr_addr=CLEAR_CMD.
  - Otherwise: no write; frame_err=1.
  - Commit latency: registers visible the cycle after the final byte_evt.
- Timeout: counter clears on every byte_evt and in IDLE; it increments each cycle in DATA/CHK. When it reaches TIMEOUT_CYCLES: abort the frame, go IDLE, pulse frame_err, leave registers unchanged. If byte_evt coincides with the timeout cycle, the byte wins and the counter clears.
- wr_strobe and frame_err are 1 only on the cycle stated above; otherwise 0. They are never both 1 in the same cycle.
- Reset mid-frame discards the partial frame and zeroes the bank.
- Back-to-back frames need no idle gap: a byte_evt the cycle after a commit is taken as the next command.

Optional Feature:
CMD_FRAME_CHECKSUM_EN
- Defined: each frame carries one extra byte after the payload. It must equal the XOR of the command and all payload bytes. State CHK waits for it (timeout applies).
  - Match: commit as above on that edge.
  - Mismatch: frame_err=1, no write, go IDLE.
- Undefined: no CHK state. The frame is 1+DATA_BYTES bytes and commit happens on the last payload byte.

Test Plan:
1. Reset, then frame 02 12 34 56 78 -> reg[2]=32'h12345678 the cycle after the last byte; wr_strobe 1 cycle; wr_addr=2; all other regs 0.
2. Frame 10 AA BB CC DD (NUM_REGS=16) -> no register change; frame_err 1 cycle. A following frame 03 00 00 00 01 -> reg[3]=1.
3. Send 05 11 22, then idle TIMEOUT_CYCLES cycles -> frame_err pulses, busy drops, reg[5] unchanged. Then 05 00 00 00 09 -> reg[5]=9 (resync).
4. Load reg[0]=1 and reg[15]=FFFFFFFF, then send FF 00 00 00 00 -> all regs 0; wr_addr=FF.
5. Assert rst low mid-frame after 07 01 02, release, send 07 00 00 00 04 -> reg[7]=4. No spurious byte event on release.
6. With CMD_FRAME_CHECKSUM_EN: frame 01 00 00 00 0F 0E -> reg[1]=0xF. Frame 01 00 00 00 0F 00 -> frame_err, reg[1] keeps its previous value.

Source files
------------

// File: rtl/cmd_frame_decoder_if.sv
// cmd_frame_decoder_if: UART byte input and register-bank outputs of the
// command-frame decoder. The decoder uses the slave modport; whatever feeds
// bytes and reads the bank uses the master modport.
interface cmd_frame_decoder_if #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_BYTES = 4
);
  logic [7:0]                       rx_data;
  logic                             rx_busy;
  logic [NUM_REGS*DATA_BYTES*8-1:0] regs_flat;
  logic                             wr_strobe;
  logic [7:0]                       wr_addr;
  logic                             frame_err;
  logic                             busy;

  modport master (
    output rx_data, rx_busy,
    input  regs_flat, wr_strobe, wr_addr, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_busy,
    output regs_flat, wr_strobe, wr_addr, frame_err, busy
  );
endinterface

// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: assembles UART command frames (command byte plus
// DATA_BYTES big-endian payload bytes) and writes one register of a
// NUM_REGS-deep bank; CLEAR_CMD zeroes the whole bank.
// Optional macro CMD_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte
// that is verified in state CHK before the commit.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command byte
// DATA  | collecting payload bytes; inter-byte timeout running
// CHK   | (checksum build only) waiting for the checksum byte
module cmd_frame_decoder #(
  parameter int         NUM_REGS       = 16,
  parameter int         DATA_BYTES     = 4,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] CLEAR_CMD      = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  cmd_frame_decoder_if.slave bus
);

  localparam int         W    = 8 * DATA_BYTES;
  localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] NREG = 8'(NUM_REGS);
  localparam logic [2:0] LAST = 3'(DATA_BYTES - 1);

`ifdef CMD_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

  state_t          r_state;
  state_t          w_next_state;
  logic            r_prev_busy;
  logic [7:0]      r_cmd;
  logic [2:0]      r_cnt;
  logic [TW-1:0]   r_tmo;
  logic [W-1:0]    r_buff;
  logic [W-1:0]    r_bank [NUM_REGS];
  logic            r_wr_strobe;
  logic [7:0]      r_wr_addr;
  logic            r_frame_err;
  logic [7:0]      r_csum;

  logic            w_byte_evt;
  logic            w_commit;
  logic            w_err;
  logic [W-1:0]    w_word;
  logic [W-1:0]    w_commit_word;
  logic [NUM_REGS*W-1:0] w_regs_flat;

  assign w_byte_evt = r_prev_busy & ~bus.rx_busy;
  // Shift form keeps the top byte of r_buff referenced even though it falls off.
  assign w_word     = (r_buff << 8) | W'(bus.rx_data);

`ifdef CMD_FRAME_CHECKSUM_EN
  assign w_commit_word = r_buff;
`else
  assign w_commit_word = w_word;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode, commit request and abort detection; a byte event
  // always takes priority over the timeout terminal count.
  always_comb begin
    w_next_state = r_state;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_byte_evt) w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_byte_evt) begin
          if (r_cnt == LAST) begin
`ifdef CMD_FRAME_CHECKSUM_EN
            w_next_state = S_CHK;
`else
            w_next_state = S_IDLE;
            w_commit     = 1'b1;
`endif
          end
        end else if (r_tmo == '0) begin
          w_next_state = S_IDLE;
          w_err        = 1'b1;
        end
      end
`ifdef CMD_FRAME_CHECKSUM_EN
      S_CHK: begin
        if (w_byte_evt) begin
          w_next_state = S_IDLE;
          if (bus.rx_data == r_csum) w_commit = 1'b1;
          else                       w_err    = 1'b1;
        end else if (r_tmo == '0) begin
          w_next_state = S_IDLE;
          w_err        = 1'b1;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Byte capture, timeout down-counter, register bank and output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_busy <= 1'b0;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_buff      <= '0;
      r_csum      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_bank[k] <= '0;
    end else begin
      r_prev_busy <= bus.rx_busy;
      r_wr_strobe <= 1'b0;
      r_frame_err <= w_err;

      if (r_state == S_IDLE || w_byte_evt) r_tmo <= TW'(TIMEOUT_CYCLES);
      else if (r_tmo != '0)                r_tmo <= r_tmo - 1'b1;

      if (w_byte_evt) begin
        if (r_state == S_IDLE) begin
          r_cmd  <= bus.rx_data;
          r_cnt  <= '0;
          r_csum <= bus.rx_data;
        end else if (r_state == S_DATA) begin
          r_buff <= w_word;
          r_cnt  <= r_cnt + 1'b1;
          r_csum <= r_csum ^ bus.rx_data;
        end
      end

      if (w_commit) begin
        if (r_cmd < NREG) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (8'(k) == r_cmd) r_bank[k] <= w_commit_word;
          r_wr_strobe <= 1'b1;
          r_wr_addr   <= r_cmd;
        end else if (r_cmd == CLEAR_CMD) begin
          for (int k = 0; k < NUM_REGS; k++) r_bank[k] <= '0;
          r_wr_strobe <= 1'b1;
          r_wr_addr   <= CLEAR_CMD;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // Flatten the bank; register k sits at bits [(k+1)*W-1 : k*W].
  always_comb begin
    w_regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) w_regs_flat[k*W +: W] = r_bank[k];
  end

  assign bus.regs_flat = w_regs_flat;
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb_cmd_frame_decoder: directed frames with hand-computed register values.
module tb_cmd_frame_decoder;
  localparam int NREG = 16;
  localparam int DB   = 4;
  localparam int TMO  = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_frame_decoder_if #(.NUM_REGS(NREG), .DATA_BYTES(DB)) bus ();

  cmd_frame_decoder #(
    .NUM_REGS(NREG), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TMO), .CLEAR_CMD(8'hFF)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] exp_bank [NREG];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < NREG; k++)
      check_val($sformatf("%s_reg%0d", tag, k), bus.regs_flat[k*32 +: 32], exp_bank[k]);
  endtask

  // Busy high for hold cycles, then falls; returns just after the edge that consumes the byte.
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_busy = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.rx_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data);
    send_byte(cmd, 3);
    for (int i = 0; i < 4; i++) send_byte(data[31-8*i -: 8], 3);
`ifdef CMD_FRAME_CHECKSUM_EN
    send_byte(cmd ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0], 3);
`endif
  endtask

  task automatic expect_write(input string tag, input logic [7:0] addr);
    @(negedge clk);
    check_val({tag, "_strobe"}, 32'(bus.wr_strobe), 32'd1);
    check_val({tag, "_err"},    32'(bus.frame_err), 32'd0);
    check_val({tag, "_addr"},   32'(bus.wr_addr),   32'(addr));
    check_bank(tag);
    @(negedge clk);
    check_val({tag, "_strobe_off"}, 32'(bus.wr_strobe), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    check_val({tag, "_err"},    32'(bus.frame_err), 32'd1);
    check_val({tag, "_strobe"}, 32'(bus.wr_strobe), 32'd0);
    check_val({tag, "_busy"},   32'(bus.busy),      32'd0);
    check_bank(tag);
    @(negedge clk);
    check_val({tag, "_err_off"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_busy = 1'b0;
    for (int k = 0; k < NREG; k++) exp_bank[k] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_strobe", 32'(bus.wr_strobe), 32'd0);
    check_val("rst_err",    32'(bus.frame_err), 32'd0);
    check_val("rst_busy",   32'(bus.busy),      32'd0);
    check_val("rst_addr",   32'(bus.wr_addr),   32'd0);
    check_bank("rst");
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rel_busy", 32'(bus.busy), 32'd0);

    // 1: basic big-endian write
    send_frame(8'h02, 32'h12345678);
    exp_bank[2] = 32'h12345678;
    expect_write("t1", 8'h02);

    // 2: out-of-range command, then recovery
    send_frame(8'h10, 32'hAABBCCDD);
    expect_err("t2");
    send_frame(8'h03, 32'h00000001);
    exp_bank[3] = 32'h00000001;
    expect_write("t2b", 8'h03);

    // 3: timeout at exactly TMO idle cycles after the last byte, then resync
    send_byte(8'h05, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    repeat (TMO) @(posedge clk);
    @(negedge clk);
    check_val("t3_err_early", 32'(bus.frame_err), 32'd0);
    check_val("t3_busy_held", 32'(bus.busy),      32'd1);
    @(posedge clk);
    expect_err("t3");
    send_frame(8'h05, 32'h00000009);
    exp_bank[5] = 32'h00000009;
    expect_write("t3b", 8'h05);

    // Byte arriving on the terminal-count cycle is accepted
    send_byte(8'h09, 3);
    send_byte(8'h00, 3);
    send_byte(8'h00, TMO - 1);
    @(negedge clk);
    check_val("late_err",  32'(bus.frame_err), 32'd0);
    check_val("late_busy", 32'(bus.busy),      32'd1);
    send_byte(8'h00, 3);
    send_byte(8'h05, 3);
`ifdef CMD_FRAME_CHECKSUM_EN
    send_byte(8'h0C, 3);
`endif
    exp_bank[9] = 32'h00000005;
    expect_write("late", 8'h09);

    // 4: clear command
    send_frame(8'h00, 32'h00000001);
    exp_bank[0] = 32'h00000001;
    expect_write("t4a", 8'h00);
    send_frame(8'h0F, 32'hFFFFFFFF);
    exp_bank[15] = 32'hFFFFFFFF;
    expect_write("t4b", 8'h0F);
    send_frame(8'hFF, 32'h00000000);
    for (int k = 0; k < NREG; k++) exp_bank[k] = '0;
    expect_write("t4c", 8'hFF);

    // 5: reset mid-frame discards the frame and zeroes the bank
    send_frame(8'h07, 32'h000000AA);
    exp_bank[7] = 32'h000000AA;
    expect_write("t5a", 8'h07);
    send_byte(8'h07, 3);
    send_byte(8'h01, 3);
    send_byte(8'h02, 3);
    #3 rst = 1'b0;
    #1;
    for (int k = 0; k < NREG; k++) exp_bank[k] = '0;
    check_val("t5_busy_rst", 32'(bus.busy), 32'd0);
    check_bank("t5_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    check_val("t5_no_evt", 32'(bus.busy), 32'd0);
    send_frame(8'h07, 32'h00000004);
    exp_bank[7] = 32'h00000004;
    expect_write("t5b", 8'h07);

`ifdef CMD_FRAME_CHECKSUM_EN
    // 6: checksum good then bad
    send_frame(8'h01, 32'h0000000F);
    exp_bank[1] = 32'h0000000F;
    expect_write("t6a", 8'h01);
    send_byte(8'h01, 3);
    send_byte(8'h00, 3);
    send_byte(8'h00, 3);
    send_byte(8'h00, 3);
    send_byte(8'h0F, 3);
    send_byte(8'h00, 3);
    expect_err("t6b");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
